shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
- Parametrised successor to the fixed 8-stage serial-in/serial-out shift chain.
- Provides:
  - configurable width
  - bidirectional shifting
  - parallel load
  - a clock enable
  - a shift counter that flags each completed WIDTH-bit word and captures it into a stable parallel output register.
- Sits between the board serial pins and downstream parallel logic, clocked from the global shift clock.

Parameters:
- WIDTH, 8: register length in bits; legal range 2..32.
- RESET_VALUE, 0: WIDTH-bit value loaded into the shift register on reset.

Ports:
- clk_sr  input  1  shift clock, rising-edge; global buffer.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; 0 = hold all state.
- mode  input  2  00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load.
- data_in  input  1  serial input bit.
- par_in  input  WIDTH  parallel load value.
- data_out  output  1  serial output bit.
- par_out  output  WIDTH  live shift register contents.
- word_out  output  WIDTH  last completed word, held stable.
- word_done  output  1  one-cycle strobe: word_out just updated.
- bit_cnt  output  clog2(WIDTH+1)  shifts accumulated in current word.

Behaviour:
- Reset (rst=1, async, no clock required):
  - sreg=RESET_VALUE, dir=0, bit_cnt=0, word_done=0, word_out=0.
  - All outputs settle within the same cycle.
  - Reset asserted mid-word discards the partial word; no word_done is emitted.
- Release: state advances on the first rising clk_sr edge with rst=0.
- en=0: every register holds, except that word_done is forced to 0 on that edge (the strobe never stretches).
- mode 00 with en=1: sreg, dir, bit_cnt and word_out hold; word_done<=0.
- mode 01 (toward MSB): sreg<={sreg[WIDTH-2:0],data_in}; dir<=0.
- mode 10 (toward LSB): sreg<={data_in,sreg[WIDTH-1:1]}; dir<=1.
- Direction change: a shift whose direction differs from current dir restarts the word, so bit_cnt<=1 after that shift.
- Same-direction shift:
  - If bit_cnt==WIDTH-1: bit_cnt<=0, word_out<=new sreg value (post-shift), word_done<=1.
  - Otherwise: bit_cnt<=bit_cnt+1, word_done<=0.
- mode 11 (parallel load): sreg<=par_in, bit_cnt<=0, word_done<=0; dir and word_out unchanged.
- data_out = dir ? sreg[0] : sreg[WIDTH-1]. It is a combinational mux of registered state, so no glitch from inputs.
- par_out = sreg, direct.
- Serial latency: with dir=0 and a continuous shift, data_in appears on data_out after WIDTH rising edges. With WIDTH=8 this matches the legacy chain.
- bit_cnt range is 0..WIDTH-1 and never reaches WIDTH.
- word_done is high for exactly one cycle per WIDTH consecutive same-direction shifts. Hold cycles and en=0 cycles between shifts do not break the word.
- word_out changes only on a word_done edge or on reset.

Test Plan:
- Reset/defaults: WIDTH=8, RESET_VALUE=8'hA5; assert rst asynchronously between edges -> par_out=A5, data_out=1, bit_cnt=0, word_done=0, word_out=00 immediately, before the next edge.
- MSB shift word: mode=01, en=1; shift bits 1,0,1,1,0,0,1,0 (first to last) -> after 8th edge, word_out=8'hB2, word_done high one cycle, bit_cnt=0; data_out shows the first input bit (1) after the 8th edge.
- LSB shift and direction restart: shift 3 bits with mode=01, then one with mode=10 -> bit_cnt=1, dir=1, data_out=sreg[0]. A further 7 mode=10 shifts of all 1s -> word_done pulse, word_out=8'hFF.
- Enable/hold gaps: 8 shifts interleaved with en=0 cycles and mode=00 cycles -> word_done pulses only on the 8th shift edge; state is unchanged across gap cycles.
- Parallel load mid-word: after 5 shifts, mode=11 with par_in=8'h3C -> par_out=3C, bit_cnt=0, no word_done, word_out retains its previous value. Then 8 MSB shifts of 0 -> data_out sequence 0,0,1,1,1,1,0,0.
- Reset mid-word: after 6 shifts, pulse rst -> bit_cnt=0, par_out=RESET_VALUE, no word_done; the next full 8 shifts produce exactly one word_done.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal shift register: bidirectional serial shift, parallel load and clock enable.
// A word counter captures each completed WIDTH-bit same-direction run into word_out.
module shift_register_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk_sr,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       data_in,
  input  logic [WIDTH-1:0]           par_in,
  output logic                       data_out,
  output logic [WIDTH-1:0]           par_out,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_TOMSB = 2'b01;
  localparam logic [1:0] MODE_TOLSB = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             shift_req;
  logic             shift_dir;

  // dir: 0 = shifting toward MSB, 1 = shifting toward LSB.
  always_comb begin
    shift_req = 1'b0;
    shift_dir = dir_q;
    if (en) begin
      if (mode == MODE_TOMSB) begin
        shift_req = 1'b1;
        shift_dir = 1'b0;
      end else if (mode == MODE_TOLSB) begin
        shift_req = 1'b1;
        shift_dir = 1'b1;
      end
    end
  end

  always_comb begin
    sreg_d = sreg_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    done_d = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: begin
          done_d = 1'b0;
        end
        MODE_TOMSB: begin
          sreg_d = {sreg_q[WIDTH-2:0], data_in};
        end
        MODE_TOLSB: begin
          sreg_d = {data_in, sreg_q[WIDTH-1:1]};
        end
        MODE_LOAD: begin
          sreg_d = par_in;
          cnt_d  = '0;
        end
        default: begin
          done_d = 1'b0;
        end
      endcase
    end

    // A direction change starts a fresh word with this shift as its first bit.
    if (shift_req) begin
      dir_d = shift_dir;
      if (shift_dir != dir_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        word_d = sreg_d;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sr or posedge rst) begin
    if (rst) begin
      sreg_q <= RESET_VALUE;
      word_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  assign data_out  = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];
  assign par_out   = sreg_q;
  assign word_out  = word_q;
  assign word_done = done_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8, RESET_VALUE=A5) with an
// arithmetic reference model checked every falling edge plus hand-computed literals.
module tb_shift_register_universal;

  localparam int             WIDTH = 8;
  localparam logic [7:0]     RV    = 8'hA5;
  localparam int             CW    = $clog2(WIDTH + 1);

  logic             clk_sr = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic [1:0]       mode   = 2'b00;
  logic             data_in = 1'b0;
  logic [WIDTH-1:0] par_in = '0;
  logic             data_out;
  logic [WIDTH-1:0] par_out;
  logic [WIDTH-1:0] word_out;
  logic             word_done;
  logic [CW-1:0]    bit_cnt;

  shift_register_universal #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk_sr    (clk_sr),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .data_in   (data_in),
    .par_in    (par_in),
    .data_out  (data_out),
    .par_out   (par_out),
    .word_out  (word_out),
    .word_done (word_done),
    .bit_cnt   (bit_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk_sr = ~clk_sr;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The register is an integer; a word is "WIDTH shifts in a row in one direction".
  int m_sreg;
  int m_run;
  int m_word;
  bit m_dir;
  bit m_done;
  bit run_chk = 1'b0;

  task automatic model_reset();
    m_sreg = int'(RV);
    m_run  = 0;
    m_word = 0;
    m_dir  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic [1:0] md, input logic d,
                            input logic [7:0] p);
    bit nd;
    m_done = 1'b0;
    if (e) begin
      if (md == 2'd1 || md == 2'd2) begin
        nd = (md == 2'd2);
        if (nd) m_sreg = (m_sreg >> 1) | (int'(d) << (WIDTH - 1));
        else    m_sreg = ((m_sreg << 1) | int'(d)) % (1 << WIDTH);
        m_run = (nd != m_dir) ? 1 : m_run + 1;
        m_dir = nd;
        if (m_run == WIDTH) begin
          m_run  = 0;
          m_word = m_sreg;
          m_done = 1'b1;
        end
      end else if (md == 2'd3) begin
        m_sreg = int'(p);
        m_run  = 0;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_sr) begin
    if (run_chk) begin
      chk("model_par_out",   32'(par_out),   32'(m_sreg));
      chk("model_data_out",  32'(data_out),  m_dir ? 32'(m_sreg % 2) : 32'((m_sreg >> (WIDTH-1)) % 2));
      chk("model_word_out",  32'(word_out),  32'(m_word));
      chk("model_word_done", 32'(word_done), 32'(m_done));
      chk("model_bit_cnt",   32'(bit_cnt),   32'(m_run));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic [1:0] md, input logic d,
                      input logic [7:0] p = 8'h00);
    en = e; mode = md; data_in = d; par_in = p;
    @(posedge clk_sr);
    model_edge(e, md, d, p);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges; outputs are checked before the next edge.
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_par_out"},   32'(par_out),   32'(RV));
    chk({tag, "_data_out"},  32'(data_out),  32'(1));
    chk({tag, "_bit_cnt"},   32'(bit_cnt),   32'(0));
    chk({tag, "_word_done"}, 32'(word_done), 32'(0));
    chk({tag, "_word_out"},  32'(word_out),  32'(0));
    #1 rst = 1'b0;
  endtask

  logic [7:0] msb_bits;
  logic [7:0] gap_bits;
  logic [7:0] load_seq;
  int         pulses;

  initial begin
    msb_bits = 8'b1011_0010;   // sent MSB-first: 1,0,1,1,0,0,1,0
    gap_bits = 8'b0110_1001;   // sent MSB-first: 0,1,1,0,1,0,0,1
    load_seq = 8'b0011_1100;   // expected data_out before each shift after loading 3C

    repeat (2) @(posedge clk_sr);
    #1;
    model_reset();
    rst = 1'b0;
    run_chk = 1'b1;

    // Reset/defaults: disturb the state, then reset asynchronously.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    async_reset("rst_async");

    // MSB word 1,0,1,1,0,0,1,0 -> B2.
    for (int i = 7; i >= 0; i--) step(1'b1, 2'b01, msb_bits[i]);
    chk("msb_word_out",  32'(word_out),  32'h B2);
    chk("msb_word_done", 32'(word_done), 32'd1);
    chk("msb_bit_cnt",   32'(bit_cnt),   32'd0);
    chk("msb_data_out",  32'(data_out),  32'd1);
    step(1'b1, 2'b00, 1'b0);
    chk("msb_done_one_cycle", 32'(word_done), 32'd0);

    // Direction restart: 97 after three 1s toward MSB, then CB after one 1 toward LSB.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b10, 1'b1);
    chk("dir_bit_cnt",  32'(bit_cnt),  32'd1);
    chk("dir_par_out",  32'(par_out),  32'h CB);
    chk("dir_data_out", 32'(data_out), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b1, 2'b10, 1'b1);
    chk("lsb_word_out",  32'(word_out),  32'h FF);
    chk("lsb_word_done", 32'(word_done), 32'd1);

    // Enable/hold gaps between shifts: first shift restarts toward MSB.
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, 2'b01, gap_bits[i]);
      if (i > 0) begin
        chk("gap_no_done", 32'(word_done), 32'd0);
        if (i % 2 == 1) step(1'b0, 2'b01, ~gap_bits[i]);
        else            step(1'b1, 2'b00, 1'b1);
        chk("gap_hold_cnt", 32'(bit_cnt), 32'(8 - i));
      end
    end
    chk("gap_word_done", 32'(word_done), 32'd1);
    chk("gap_word_out",  32'(word_out),  32'h 69);

    // Parallel load mid-word.
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b11, 1'b0, 8'h3C);
    chk("load_par_out",   32'(par_out),   32'h 3C);
    chk("load_bit_cnt",   32'(bit_cnt),   32'd0);
    chk("load_word_done", 32'(word_done), 32'd0);
    chk("load_word_out",  32'(word_out),  32'h 69);
    for (int i = 7; i >= 0; i--) begin
      chk("load_serial_out", 32'(data_out), 32'(load_seq[i]));
      step(1'b1, 2'b01, 1'b0);
    end
    chk("load_word_done_after8", 32'(word_done), 32'd1);
    chk("load_word_out_after8",  32'(word_out),  32'h 00);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, 1'b1);
    chk("mid_bit_cnt_before", 32'(bit_cnt), 32'd6);
    async_reset("rst_mid");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, 1'b1);
      if (word_done) pulses++;
    end
    chk("mid_word_pulses", 32'(pulses),   32'd1);
    chk("mid_word_out",    32'(word_out), 32'h FF);

    step(1'b1, 2'b00, 1'b0);
    @(negedge clk_sr);
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
